sy_ppl_fpr_wb: RTL
==================

// Module: sy_ppl_fpr_wb
// PURPOSE
//  FP writeback unit: the producer side of the physical FP register file write ports.
//  Accepts FPU results and LSU FP-load results over valid/ready and buffers each in a small FIFO.
//  Drives the two rdst write ports (lsu_reg__*, fpu_reg__*) and keeps a per-physical-register
//  ready bitmap, which dec uses to wake up FP source operands.
// PARAMETERS
//  FIFO_DEPTH  2           entries per source FIFO (power of 2, >=2)
//  NUM_PREG    PHY_FP_REG  physical FP registers tracked (sy_pkg)
//  IDX_W       PHY_REG_WTH physical index width (sy_pkg)
// PORTS
//  clk_i                 in   1               clock
//  rst_ni                in   1               asynchronous active-low reset
//  fpu_wb_vld_i          in   1               FPU result valid
//  fpu_wb_rdy_o          out  1               FPU FIFO can accept
//  fpu_wb_idx_i          in   IDX_W           FPU destination phys idx
//  fpu_wb_data_i         in   DWTH            FPU result data
//  lsu_wb_vld_i          in   1               LSU FP load result valid
//  lsu_wb_rdy_o          out  1               LSU FIFO can accept
//  lsu_wb_idx_i          in   IDX_W           LSU destination phys idx
//  lsu_wb_data_i         in   DWTH            LSU load data (already NaN-boxed)
//  alloc_en_i            in   1               rename allocates a phys FP reg
//  alloc_idx_i           in   IDX_W           allocated idx (ready bit cleared)
//  flush_i               in   1               pipeline flush
//  fpu_reg__rdst_en_o    out  1               write-port enable, FPU lane
//  fpu_reg__rdst_idx_o   out  IDX_W           write index, FPU lane
//  fpu_reg__rdst_data_o  out  DWTH            write data, FPU lane
//  lsu_reg__rdst_en_o    out  1               write-port enable, LSU lane
//  lsu_reg__rdst_idx_o   out  IDX_W           write index, LSU lane
//  lsu_reg__rdst_data_o  out  DWTH            write data, LSU lane
//  fpr_rdy_o             out  NUM_PREG        per phys reg: data present in file
// BEHAVIOUR
//  Reset (async, rst_ni=0): FIFOs empty; all *_rdst_en_o=0, idx/data=0; *_rdy_o=1; fpr_rdy_o all ones.
//  Enqueue: handshake on vld&rdy. rdy_o = !full and does not depend on vld_i in the same cycle.
//  Full FIFO: rdy_o=0; vld_i is held by the source; no drop, no overwrite.
//  Write-port outputs are registered. FIFO head popped in cycle N drives rdst_en/idx/data in cycle N+1.
//  Minimum latency is enqueue at edge N -> rdst_en_o high in cycle N+1. One pop per lane per cycle.
//  Simultaneous push+pop on a full FIFO is allowed: occupancy is unchanged and rdy_o stays 0 that cycle.
//  Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
//  Same-idx collision: both heads valid with the same idx in the same cycle.
//   - The FPU head pops; the LSU head is held one cycle and writes next (LSU value is final).
//   - A sim-only assertion flags the collision, because renaming guarantees it never occurs.
//  Ready bitmap: bit i set the cycle after rdst_en_o for idx i (the file holds the data then).
//  Ready bitmap: bit i cleared the cycle after alloc_en_i with idx i.
//  Alloc and write completion for the same idx in the same cycle: the clear wins.
//  flush_i: both FIFOs emptied and all rdst_en_o=0 next cycle.
//   - Writes already registered on the output in the flush cycle still complete.
//   - Enqueues in the flush cycle are dropped; the bitmap is unchanged.
//   - Rename restores readiness via its own mechanism.
//  Flush and alloc in the same cycle: alloc is still applied.
//  Index >= NUM_PREG is illegal: assertion fires, no bitmap update.
// STRUCTURE
//  sy_pkg: typedef fpr_wb_t {logic[PHY_REG_WTH-1:0] idx; logic[DWTH-1:0] data;}.
//  sy_pkg: constant FPR_WB_FIFO_DEPTH = 2.
//  Sub-module sy_ppl_fpr_wb_fifo:
//   - generic fpr_wb_t FIFO with push/pop/flush, full/empty, registered rdy.
//   - instantiated twice (FPU, LSU).
//  Top level: collision/arbitration logic, output registers, ready bitmap.
// TESTING
//  1 Reset mid-traffic: rst_ni low with both FIFOs full -> all en_o=0, rdy_o=1, fpr_rdy_o=all ones next edge.
//  2 Single FPU write: idx=5, data=0x3FF0_0000_0000_0000 at cycle 0 -> fpu_reg__rdst_en_o=1 cycle 1; fpr_rdy_o[5]=1 cycle 2.
//  3 Backpressure: 3 LSU pushes back-to-back, no pops possible -> third stalls with lsu_wb_rdy_o=0.
//    When drained, data is written in order with no loss.
//  4 Collision: FPU idx=9 data=A and LSU idx=9 data=B in same cycle -> FPU writes A cycle 1, LSU writes B cycle 2.
//    Assertion is flagged.
//  5 Alloc vs write: alloc_idx=7 while idx 7 write completes -> fpr_rdy_o[7]=0.
//  6 Flush: 2 entries queued in each FIFO, flush_i pulse -> no rdst_en_o after the flush+1 cycle.
//    Both rdy_o=1; the bitmap is unchanged.

Source files
------------

// File: rtl/sy_pkg.sv
// Shared types and sizing for the FP writeback path.
// Physical FP register file geometry and the writeback bundle.
package sy_pkg;

   localparam int PHY_FP_REG        = 48;
   localparam int PHY_REG_WTH       = 6;
   localparam int DWTH              = 64;
   localparam int FPR_WB_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [PHY_REG_WTH-1:0] idx;
      logic [DWTH-1:0]        data;
   } fpr_wb_t;

endpackage

// File: rtl/sy_ppl_fpr_wb_if.sv
// Valid/ready writeback channel from a result producer (FPU or LSU).
// The master drives the result, the slave answers with ready.
interface sy_ppl_fpr_wb_if;
   import sy_pkg::*;

   logic                   vld;
   logic                   rdy;
   logic [PHY_REG_WTH-1:0] idx;
   logic [DWTH-1:0]        data;

   modport master (output vld, idx, data, input rdy);
   modport slave  (input vld, idx, data, output rdy);

endinterface

// File: rtl/sy_ppl_fpr_wb_fifo.sv
// Small fall-through FIFO of writeback bundles with a registered ready.
// An empty FIFO presents the incoming bundle directly as its head.
module sy_ppl_fpr_wb_fifo
   import sy_pkg::*;
#(
   parameter int DEPTH = FPR_WB_FIFO_DEPTH
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  fpr_wb_t din_i,
   input  logic    pop_i,
   input  logic    flush_i,
   output logic    head_vld_o,
   output fpr_wb_t head_o,
   output logic    rdy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fpr_wb_t        mem_q [DEPTH];
   logic [PW-1:0]  wptr_q, wptr_d;
   logic [PW-1:0]  rptr_q, rptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rdy_q, rdy_d;
   logic           empty, full, bypass;
   logic           wr_en, rd_en;

   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == CW'(DEPTH));
   assign head_vld_o = !empty || push_i;
   assign head_o     = empty ? din_i : mem_q[rptr_q];
   assign rdy_o      = rdy_q;

   // A push consumed straight through the head never lands in storage.
   assign bypass = empty && push_i && pop_i;
   assign wr_en  = push_i && !bypass && !flush_i
                && (!full || pop_i);
   assign rd_en  = pop_i && !empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end
   end

   assign rdy_d = (cnt_d != CW'(DEPTH));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         rdy_q  <= 1'b1;
         mem_q  <= '{default: '0};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
         if (wr_en) mem_q[wptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/sy_ppl_fpr_wb.sv
// FP writeback: buffers FPU and LSU results, drives both FP register
// file write ports and tracks per-physical-register data readiness.
module sy_ppl_fpr_wb
   import sy_pkg::*;
#(
   parameter int FIFO_DEPTH = FPR_WB_FIFO_DEPTH,
   parameter int NUM_PREG   = PHY_FP_REG,
   parameter int IDX_W      = PHY_REG_WTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   sy_ppl_fpr_wb_if.slave      fpu_wb,
   sy_ppl_fpr_wb_if.slave      lsu_wb,
   input  logic                alloc_en_i,
   input  logic [IDX_W-1:0]    alloc_idx_i,
   input  logic                flush_i,
   output logic                fpu_reg__rdst_en_o,
   output logic [IDX_W-1:0]    fpu_reg__rdst_idx_o,
   output logic [DWTH-1:0]     fpu_reg__rdst_data_o,
   output logic                lsu_reg__rdst_en_o,
   output logic [IDX_W-1:0]    lsu_reg__rdst_idx_o,
   output logic [DWTH-1:0]     lsu_reg__rdst_data_o,
   output logic [NUM_PREG-1:0] fpr_rdy_o
);

   localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PREG);

   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} < NP;
   endfunction

   fpr_wb_t             fpu_in, lsu_in;
   fpr_wb_t             fpu_head, lsu_head;
   fpr_wb_t             fpu_out_q, lsu_out_q;
   logic                fpu_rdy, lsu_rdy;
   logic                fpu_push, lsu_push;
   logic                fpu_hv, lsu_hv;
   logic                fpu_pop, lsu_pop;
   logic                collide;
   logic                fpu_en_q, lsu_en_q;
   logic [NUM_PREG-1:0] map_q, map_d;

   assign fpu_in    = {fpu_wb.idx, fpu_wb.data};
   assign lsu_in    = {lsu_wb.idx, lsu_wb.data};
   assign fpu_wb.rdy = fpu_rdy;
   assign lsu_wb.rdy = lsu_rdy;

   // Anything offered during a flush is discarded.
   assign fpu_push = fpu_wb.vld && fpu_rdy && !flush_i;
   assign lsu_push = lsu_wb.vld && lsu_rdy && !flush_i;

   sy_ppl_fpr_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fpu_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (fpu_push),
      .din_i      (fpu_in),
      .pop_i      (fpu_pop),
      .flush_i    (flush_i),
      .head_vld_o (fpu_hv),
      .head_o     (fpu_head),
      .rdy_o      (fpu_rdy)
   );

   sy_ppl_fpr_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (lsu_push),
      .din_i      (lsu_in),
      .pop_i      (lsu_pop),
      .flush_i    (flush_i),
      .head_vld_o (lsu_hv),
      .head_o     (lsu_head),
      .rdy_o      (lsu_rdy)
   );

   // On a same-index clash the LSU waits so its value lands last.
   assign collide = fpu_hv && lsu_hv
                 && (fpu_head.idx == lsu_head.idx);
   assign fpu_pop = fpu_hv && !flush_i;
   assign lsu_pop = lsu_hv && !flush_i && !collide;

   always_comb begin
      map_d = map_q;
      if (fpu_en_q && idx_ok(fpu_out_q.idx))
         map_d[fpu_out_q.idx] = 1'b1;
      if (lsu_en_q && idx_ok(lsu_out_q.idx))
         map_d[lsu_out_q.idx] = 1'b1;
      if (alloc_en_i && idx_ok(alloc_idx_i))
         map_d[alloc_idx_i] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fpu_en_q  <= 1'b0;
         lsu_en_q  <= 1'b0;
         fpu_out_q <= '0;
         lsu_out_q <= '0;
         map_q     <= '1;
      end else begin
         fpu_en_q <= fpu_pop;
         lsu_en_q <= lsu_pop;
         if (fpu_pop) fpu_out_q <= fpu_head;
         if (lsu_pop) lsu_out_q <= lsu_head;
         map_q <= map_d;
      end
   end

   assign fpu_reg__rdst_en_o   = fpu_en_q;
   assign fpu_reg__rdst_idx_o  = fpu_out_q.idx;
   assign fpu_reg__rdst_data_o = fpu_out_q.data;
   assign lsu_reg__rdst_en_o   = lsu_en_q;
   assign lsu_reg__rdst_idx_o  = lsu_out_q.idx;
   assign lsu_reg__rdst_data_o = lsu_out_q.data;
   assign fpr_rdy_o            = map_q;

   // Renaming never hands out one index to both lanes at once.
   a_collide: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !collide)
      else $warning("fpr_wb: same-idx FPU/LSU writeback collision");

   a_fpu_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fpu_wb.vld |-> idx_ok(fpu_wb.idx))
      else $error("fpr_wb: FPU index out of range");

   a_lsu_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lsu_wb.vld |-> idx_ok(lsu_wb.idx))
      else $error("fpr_wb: LSU index out of range");

   a_alloc_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
      alloc_en_i |-> idx_ok(alloc_idx_i))
      else $error("fpr_wb: alloc index out of range");

endmodule
